// File: rtl/gmii_tx_mac_pkg.sv
// Shared types and constants for the GMII transmit MAC.
// No logic; pure declarations plus the byte-wise CRC-32 step function.
// Consumers: gmii_tx_mac_if, gmii_tx_mac, gmii_tx_mac_crc32.
package gmii_tx_mac_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int MIN_FRAME_LEN = 60;   // bytes before FCS; pad target when FCS is generated

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;  // reflected form
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_DRAIN,
    ST_IFG
  } tx_state_t;

  // One byte through the reflected CRC-32 register, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_mac_if.sv
// Byte-stream handshake from the port egress buffer into the TX MAC.
// master: egress buffer (drives data/valid/last, sees ready).
// slave : MAC (sees data/valid/last, drives ready). Transfer on valid & ready.
interface gmii_tx_mac_if;
  import gmii_tx_mac_pkg::*;

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/gmii_tx_mac_crc32.sv
// Byte-wise CRC-32 accumulator (reflected, init all-ones); caller inverts for FCS.
// Latency: crc_o reflects a byte one cycle after en_i; clr_i has priority over en_i.
// Backpressure: none, consumes one byte per enabled cycle.
// Ports: clk_i, rst_n (async active-low), clr_i, en_i, data_i[7:0], crc_o[31:0].
module gmii_tx_mac_crc32
  import gmii_tx_mac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC32_INIT;
    end else if (clr_i) begin
      crc_q <= CRC32_INIT;
    end else if (en_i) begin
      crc_q <= crc32_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_mac.sv
// Per-port GMII TX MAC: preamble, SFD, frame bytes, [pad + FCS], then inter-frame gap.
// Latency: valid in IDLE at t -> 0x55 on wire t+1..t+7, SFD t+8; byte accepted at n is on the wire at n+1.
// Backpressure: ready only in SFD/DATA/DRAIN; an empty cycle mid-frame aborts with one TX_ER cycle.
// Ports: gmii_tx_clk_i, gmii_tx_rst_n (async active-low), tx_if (slave byte stream),
//        gmii_tx_data_o/en_o/er_o (registered GMII), tx_busy_o, tx_frame_done_o, tx_underrun_o.
// Build option: define TX_FCS_EN to pad runts to MIN_FRAME_LEN and append CRC-32; otherwise
//        the stream is assumed to carry its own FCS and is sent unmodified.
module gmii_tx_mac
  import gmii_tx_mac_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12
) (
  input  logic                  gmii_tx_clk_i,
  input  logic                  gmii_tx_rst_n,
  gmii_tx_mac_if.slave          tx_if,
  output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
  output logic                  gmii_tx_en_o,
  output logic                  gmii_tx_er_o,
  output logic                  tx_busy_o,
  output logic                  tx_frame_done_o,
  output logic                  tx_underrun_o
);

  localparam int CW = 8;

  tx_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;      // preamble / FCS byte / IFG position
  logic                  abort_q, abort_d;  // current frame was cut by an underrun
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  txen_q, txen_d;
  logic                  txer_q, txer_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  unr_q, unr_d;
  logic                  ready;

`ifdef TX_FCS_EN
  // Frame byte count is only consumed by the pad decision, so it exists only with FCS generation.
  logic [10:0] bcnt_q, bcnt_d, bcnt_inc;
  logic        crc_clr, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc, fcs;

  assign bcnt_inc = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
  assign fcs      = ~crc;

  gmii_tx_mac_crc32 u_crc (
    .clk_i  (gmii_tx_clk_i),
    .rst_n  (gmii_tx_rst_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (crc_din),
    .crc_o  (crc)
  );
`endif

  // The comb block decides what goes on the wire next cycle; the output flops hold it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    txd_d   = '0;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    done_d  = 1'b0;
    unr_d   = 1'b0;
    ready   = 1'b0;
`ifdef TX_FCS_EN
    bcnt_d  = bcnt_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = tx_if.tx_data;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_if.tx_valid) begin
          state_d = ST_PREAMBLE;
          cnt_d   = '0;
          abort_d = 1'b0;
          txen_d  = 1'b1;
          txd_d   = PREAMBLE_BYTE;
`ifdef TX_FCS_EN
          bcnt_d  = '0;
          crc_clr = 1'b1;
`endif
        end
      end
      ST_PREAMBLE: begin
        txen_d = 1'b1;
        if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
          state_d = ST_SFD;
          txd_d   = SFD_BYTE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          txd_d = PREAMBLE_BYTE;
        end
      end
      // Ready already while SFD is on the wire so the first byte follows SFD with no gap.
      ST_SFD, ST_DATA: begin
        ready = 1'b1;
        if (tx_if.tx_valid) begin
          txen_d  = 1'b1;
          txd_d   = tx_if.tx_data;
          state_d = ST_DATA;
`ifdef TX_FCS_EN
          crc_en  = 1'b1;
          bcnt_d  = bcnt_inc;
`endif
          if (tx_if.tx_last) begin
            cnt_d = '0;
`ifdef TX_FCS_EN
            state_d = (bcnt_inc < 11'(MIN_FRAME_LEN)) ? ST_PAD : ST_FCS;
`else
            state_d = ST_IFG;
`endif
          end
        end else begin
          // Wire cannot stall: poison the frame with one error cycle.
          state_d = ST_ABORT;
          txen_d  = 1'b1;
          txer_d  = 1'b1;
          unr_d   = 1'b1;
          abort_d = 1'b1;
        end
      end
`ifdef TX_FCS_EN
      ST_PAD: begin
        txen_d  = 1'b1;
        crc_en  = 1'b1;
        crc_din = '0;
        bcnt_d  = bcnt_inc;
        if (bcnt_inc >= 11'(MIN_FRAME_LEN)) begin
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        txen_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_d = fcs[7:0];
          2'd1:    txd_d = fcs[15:8];
          2'd2:    txd_d = fcs[23:16];
          default: txd_d = fcs[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      ST_ABORT: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        ready = 1'b1;
        if (tx_if.tx_valid && tx_if.tx_last) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end
      end
      // First IFG state cycle still shows the final frame byte; the registered done pulse
      // therefore lands on the first en=0 cycle.
      ST_IFG: begin
        done_d = (cnt_q == '0) && !abort_q;
        if (cnt_q == CW'(IFG_LEN - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Covers the final IFG cycle, which is already IDLE in state terms.
    busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
  end

  always_ff @(posedge gmii_tx_clk_i or negedge gmii_tx_rst_n) begin
    if (!gmii_tx_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      txd_q   <= '0;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
`ifdef TX_FCS_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      unr_q   <= unr_d;
`ifdef TX_FCS_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign tx_if.tx_ready  = ready;
  assign gmii_tx_data_o  = txd_q;
  assign gmii_tx_en_o    = txen_q;
  assign gmii_tx_er_o    = txer_q;
  assign tx_busy_o       = busy_q;
  assign tx_frame_done_o = done_q;
  assign tx_underrun_o   = unr_q;

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed bench for gmii_tx_mac: reset, full frame, back-to-back IFG, underrun, reset mid-frame,
// and (with TX_FCS_EN) pad + FCS generation against an independent bit-serial CRC model.
// Wire activity is logged every falling edge and checked against hand-built expected sequences.
module tb_gmii_tx_mac;
  import gmii_tx_mac_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] txd;
  logic       txen, txer, busy, done, unr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fr [0:255];

  bit         cap_on = 1'b0;
  bit         c_en[$], c_er[$], c_busy[$], c_done[$], c_unr[$], c_vld[$];
  logic [7:0] c_dat[$];

  always #4 clk = ~clk;

  gmii_tx_mac_if tx_if ();

  gmii_tx_mac dut (
    .gmii_tx_clk_i   (clk),
    .gmii_tx_rst_n   (rst_n),
    .tx_if           (tx_if),
    .gmii_tx_data_o  (txd),
    .gmii_tx_en_o    (txen),
    .gmii_tx_er_o    (txer),
    .tx_busy_o       (busy),
    .tx_frame_done_o (done),
    .tx_underrun_o   (unr)
  );

  always @(negedge clk) begin
    if (cap_on) begin
      c_en.push_back(txen);
      c_er.push_back(txer);
      c_dat.push_back(txd);
      c_busy.push_back(busy);
      c_done.push_back(done);
      c_unr.push_back(unr);
      c_vld.push_back(tx_if.tx_valid);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_cap();
    c_en = {}; c_er = {}; c_dat = {}; c_busy = {}; c_done = {}; c_unr = {}; c_vld = {};
    cap_on = 1'b1;
  endtask

  task automatic fill_frame(input int len, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 256; i++) fr[i] = (i < len) ? 8'(base + step * 8'(i)) : 8'h00;
  endtask

  function automatic int first_en(input int from);
    for (int i = from; i < c_en.size(); i++) if (c_en[i]) return i;
    return -1;
  endfunction

  function automatic int first_idle(input int from);
    for (int i = from; i < c_en.size(); i++) if (!c_en[i]) return i;
    return -1;
  endfunction

  function automatic int first_vld();
    for (int i = 0; i < c_vld.size(); i++) if (c_vld[i]) return i;
    return -1;
  endfunction

  // Bit-serial reflected CRC-32 over fr[0..n-1], final inversion applied.
  function automatic logic [31:0] crc_ref(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ fr[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // Expected {en, er, data} at wire offset i from the first preamble byte.
  // body = bytes after SFD before FCS (data plus any pad, pad already zero in fr).
  function automatic logic [9:0] exp_wire(input int i, input int body, input bit has_fcs,
                                          input logic [31:0] fcs);
    logic [31:0] sh;
    if (i < 7) return {2'b10, 8'h55};
    if (i == 7) return {2'b10, 8'hD5};
    if (i < 8 + body) return {2'b10, fr[i-8]};
    if (has_fcs && i < 12 + body) begin
      sh = fcs >> (8 * (i - 8 - body));
      return {2'b10, sh[7:0]};
    end
    return 10'h000;
  endfunction

  // Offers fr[0..len-1]; one valid=0 cycle is inserted once gap_at bytes have been accepted.
  task automatic drive_frame(input int len, input int gap_at);
    int   i = 0;
    int   guard = 0;
    bit   gapped = 1'b0;
    logic acc;
    while (i < len && guard < 1000) begin
      if (i == gap_at && !gapped) begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_last  = 1'b0;
        gapped = 1'b1;
      end else begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = fr[i];
        tx_if.tx_last  = (i == len - 1);
      end
      @(negedge clk);
      acc = tx_if.tx_valid & tx_if.tx_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;
    vectors++;
    if (i < len) begin
      miscompares++;
      $display("FAIL drive_timeout accepted=%0d required=%0d", i, len);
    end
  endtask

  // Checks the whole wire image of one frame starting at s, plus the following IFG.
  task automatic check_frame(input string nm, input int s, input int body, input bit has_fcs,
                             input logic [31:0] fcs);
    int          total;
    logic [9:0]  got, exp;
    total = 8 + body + (has_fcs ? 4 : 0);
    vectors++;
    if (s < 0 || s + total + 12 > c_en.size()) begin
      miscompares++;
      $display("FAIL %s_capture start=%0d size=%0d required_end=%0d", nm, s, c_en.size(), s + total + 12);
      return;
    end
    for (int i = 0; i < total + 12; i++) begin
      vectors++;
      got = {c_en[s+i], c_er[s+i], c_dat[s+i]};
      exp = exp_wire(i, body, has_fcs, fcs);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s_wire[%0d] got=%h exp=%h", nm, i, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0; tx_if.tx_last = 1'b0; tx_if.tx_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (txen !== 1'b0) begin miscompares++; $display("FAIL reset_en got=%b exp=0", txen); end
    vectors++; if (txer !== 1'b0) begin miscompares++; $display("FAIL reset_er got=%b exp=0", txer); end
    vectors++; if (txd !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=00", txd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (unr !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got=%b exp=0", unr); end
    vectors++; if (tx_if.tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", tx_if.tx_ready); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (txen !== 1'b0 || tx_if.tx_ready !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset en=%b ready=%b exp=0/0", txen, tx_if.tx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_64();
    int k, s, nd;
    fill_frame(60, 8'h00, 8'h01);
    fr[60] = 8'hEF; fr[61] = 8'hBE; fr[62] = 8'hAD; fr[63] = 8'hDE;
    start_cap();
    drive_frame(64, -1);
    repeat (40) @(posedge clk);
    #1; cap_on = 1'b0;
    k = first_vld();
    s = first_en(0);
    vectors++; if (s !== k + 1) begin miscompares++; $display("FAIL f64_start got=%0d exp=%0d", s, k + 1); end
    check_frame("f64", s, 64, 1'b0, 32'h0);
    if (s < 0 || s + 85 > c_en.size()) return;
    vectors++; if (c_done[s+72] !== 1'b1) begin miscompares++; $display("FAIL f64_done_pos got=%b exp=1", c_done[s+72]); end
    nd = 0; foreach (c_done[i]) nd += int'(c_done[i]);
    vectors++; if (nd != 1) begin miscompares++; $display("FAIL f64_done_count got=%0d exp=1", nd); end
    nd = 0; foreach (c_unr[i]) nd += int'(c_unr[i]);
    vectors++; if (nd != 0) begin miscompares++; $display("FAIL f64_underrun_count got=%0d exp=0", nd); end
    vectors++; if (c_busy[s] !== 1'b1) begin miscompares++; $display("FAIL f64_busy_first got=%b exp=1", c_busy[s]); end
    vectors++; if (c_busy[s+83] !== 1'b1) begin miscompares++; $display("FAIL f64_busy_ifg_end got=%b exp=1", c_busy[s+83]); end
    vectors++; if (c_busy[s+84] !== 1'b0) begin miscompares++; $display("FAIL f64_busy_after got=%b exp=0", c_busy[s+84]); end
  endtask

  task automatic test_back_to_back();
    int s1, e1, s2, e2, nd;
    start_cap();
    fill_frame(16, 8'hA0, 8'h01);
    drive_frame(16, -1);
    fill_frame(16, 8'hB0, 8'h01);
    drive_frame(16, -1);
    repeat (40) @(posedge clk);
    #1; cap_on = 1'b0;
    s1 = first_en(0);
    e1 = (s1 < 0) ? -1 : first_idle(s1);
    s2 = (e1 < 0) ? -1 : first_en(e1);
    e2 = (s2 < 0) ? -1 : first_idle(s2);
    vectors++; if (e1 - s1 != 24) begin miscompares++; $display("FAIL b2b_len1 got=%0d exp=24", e1 - s1); end
    vectors++; if (s2 - e1 != 12) begin miscompares++; $display("FAIL b2b_gap got=%0d exp=12", s2 - e1); end
    vectors++; if (e2 - s2 != 24) begin miscompares++; $display("FAIL b2b_len2 got=%0d exp=24", e2 - s2); end
    if (s2 < 0 || s2 + 9 > c_dat.size()) return;
    vectors++; if (c_dat[s2] !== 8'h55) begin miscompares++; $display("FAIL b2b_pre2 got=%h exp=55", c_dat[s2]); end
    vectors++; if (c_dat[s2+7] !== 8'hD5) begin miscompares++; $display("FAIL b2b_sfd2 got=%h exp=d5", c_dat[s2+7]); end
    vectors++; if (c_dat[s2+8] !== 8'hB0) begin miscompares++; $display("FAIL b2b_data2 got=%h exp=b0", c_dat[s2+8]); end
    nd = 0; foreach (c_done[i]) nd += int'(c_done[i]);
    vectors++; if (nd != 2) begin miscompares++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
  endtask

  task automatic test_underrun();
    int         s, nd, nen;
    logic [9:0] got, exp;
    fill_frame(40, 8'h10, 8'h01);
    start_cap();
    drive_frame(40, 20);
    repeat (40) @(posedge clk);
    #1; cap_on = 1'b0;
    s = first_en(0);
    vectors++;
    if (s < 0 || s + 60 > c_en.size()) begin
      miscompares++; $display("FAIL unr_capture start=%0d size=%0d", s, c_en.size()); return;
    end
    for (int i = 0; i < 29; i++) begin
      vectors++;
      got = {c_en[s+i], c_er[s+i], c_dat[s+i]};
      exp = (i == 28) ? 10'h300 : exp_wire(i, 40, 1'b0, 32'h0);
      if (got !== exp) begin miscompares++; $display("FAIL unr_wire[%0d] got=%h exp=%h", i, got, exp); end
    end
    nen = 0;
    for (int i = s + 29; i < c_en.size(); i++) nen += int'(c_en[i]) + int'(c_er[i]);
    vectors++; if (nen != 0) begin miscompares++; $display("FAIL unr_tail_active got=%0d exp=0", nen); end
    vectors++; if (c_unr[s+28] !== 1'b1) begin miscompares++; $display("FAIL unr_pulse_pos got=%b exp=1", c_unr[s+28]); end
    nd = 0; foreach (c_unr[i]) nd += int'(c_unr[i]);
    vectors++; if (nd != 1) begin miscompares++; $display("FAIL unr_pulse_count got=%0d exp=1", nd); end
    nd = 0; foreach (c_done[i]) nd += int'(c_done[i]);
    vectors++; if (nd != 0) begin miscompares++; $display("FAIL unr_done_count got=%0d exp=0", nd); end
    vectors++; if (c_busy[c_busy.size()-1] !== 1'b0) begin miscompares++; $display("FAIL unr_busy_end got=1 exp=0"); end
  endtask

  task automatic test_reset_mid();
    int k, s;
    tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'hAA; tx_if.tx_last = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    vectors++; if (txen !== 1'b1) begin miscompares++; $display("FAIL rstmid_active got=%b exp=1", txen); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (txen !== 1'b0) begin miscompares++; $display("FAIL rstmid_en got=%b exp=0", txen); end
    vectors++; if (txer !== 1'b0) begin miscompares++; $display("FAIL rstmid_er got=%b exp=0", txer); end
    vectors++; if (tx_if.tx_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got=%b exp=0", tx_if.tx_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    tx_if.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_frame(8, 8'hC0, 8'h01);
    start_cap();
    drive_frame(8, -1);
    repeat (80) @(posedge clk);
    #1; cap_on = 1'b0;
    k = first_vld();
    s = first_en(0);
    vectors++; if (s !== k + 1) begin miscompares++; $display("FAIL rstmid_restart got=%0d exp=%0d", s, k + 1); end
`ifdef TX_FCS_EN
    check_frame("rstmid", s, 60, 1'b1, crc_ref(60));
`else
    check_frame("rstmid", s, 8, 1'b0, 32'h0);
`endif
  endtask

`ifdef TX_FCS_EN
  task automatic test_crc_model();
    logic [31:0] c;
    for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
    c = crc_ref(9);
    vectors++; if (c !== 32'hCBF43926) begin miscompares++; $display("FAIL crc_model got=%h exp=cbf43926", c); end
  endtask

  task automatic test_pad_fcs();
    int s, nd;
    fill_frame(24, 8'h30, 8'h05);
    start_cap();
    drive_frame(24, -1);
    repeat (80) @(posedge clk);
    #1; cap_on = 1'b0;
    s = first_en(0);
    check_frame("pad", s, 60, 1'b1, crc_ref(60));
    if (s < 0 || s + 73 > c_done.size()) return;
    vectors++; if (c_done[s+72] !== 1'b1) begin miscompares++; $display("FAIL pad_done_pos got=%b exp=1", c_done[s+72]); end
    nd = 0; foreach (c_done[i]) nd += int'(c_done[i]);
    vectors++; if (nd != 1) begin miscompares++; $display("FAIL pad_done_count got=%0d exp=1", nd); end
  endtask

  task automatic test_long_fcs();
    int s, e;
    fill_frame(100, 8'h03, 8'h07);
    start_cap();
    drive_frame(100, -1);
    repeat (40) @(posedge clk);
    #1; cap_on = 1'b0;
    s = first_en(0);
    e = (s < 0) ? -1 : first_idle(s);
    vectors++; if (e - s != 112) begin miscompares++; $display("FAIL long_len got=%0d exp=112", e - s); end
    check_frame("long", s, 100, 1'b1, crc_ref(100));
  endtask
`endif

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
`ifdef TX_FCS_EN
    test_crc_model();
    test_pad_fcs();
    test_long_fcs();
`else
    test_frame_64();
    test_back_to_back();
`endif
    test_underrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
